// File: rtl/loader_read_arbiter.sv
// Round-robin arbiter that shares one external read port among NUM_REQ loaders.
// Optional WAIT timeout is compiled in with macro LOADER_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no read in flight; picks the next pending requester
// ISSUE  | oMemReadReq high for one cycle with the granted address
// WAIT   | waiting for iMemReadDataValid (or timeout)
// RETURN | strobe oReqReadDataValid[grant], release the requester
module loader_read_arbiter #(
  parameter int NUM_REQ              = 2,
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                                    iClk,
  input  logic                                    iReset,
  input  logic [NUM_REQ-1:0]                      iReqReadReq,
  input  logic [NUM_REQ*INTERFACE_ADDR_WIDTH-1:0] iReqReadAddress,
  output logic [INTERFACE_WIDTH-1:0]              oReqReadData,
  output logic [NUM_REQ-1:0]                      oReqReadDataValid,
  output logic [NUM_REQ-1:0]                      oReqBusy,
  output logic                                    oMemReadReq,
  output logic [INTERFACE_ADDR_WIDTH-1:0]         oMemReadAddress,
  input  logic [INTERFACE_WIDTH-1:0]              iMemReadData,
  input  logic                                    iMemReadDataValid,
  output logic                                    oOverrun,
  output logic                                    oTimeout
);

  localparam int IdxW = $clog2(NUM_REQ);
  localparam int AW   = INTERFACE_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} stateT;

  stateT                state;
  stateT                stateNext;
  logic [NUM_REQ-1:0]   pending;
  logic [AW-1:0]        pendAddr [NUM_REQ];
  logic [IdxW-1:0]      grant;
  logic [IdxW-1:0]      rrPtr;
  logic [IdxW-1:0]      nextGrant;
  logic [IdxW-1:0]      cand;
  logic                 found;
  logic                 anyPend;
  logic [NUM_REQ-1:0]   clrVec;
  logic                 loadGrant;
  logic                 dataLoad;
  logic [INTERFACE_WIDTH-1:0] dataNext;
  logic                 waitExpired;

  // Search starts one past the last served requester.
  always_comb begin
    nextGrant = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((int'(rrPtr) + k) % NUM_REQ);
      if (!found && pending[cand]) begin
        found     = 1'b1;
        nextGrant = cand;
      end
    end
  end

  assign anyPend           = |pending;
  assign clrVec            = (state == RETURN) ? (NUM_REQ'(1) << grant) : '0;
  assign oReqReadDataValid = clrVec;
  assign oReqBusy          = pending;
  assign oMemReadReq       = (state == ISSUE);

  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadGrant = 1'b0;
    dataLoad  = 1'b0;
    dataNext  = iMemReadData;
    case (state)
      IDLE: begin
        if (anyPend) begin
          loadGrant = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT;
      WAIT: begin
        if (iMemReadDataValid) begin
          dataLoad  = 1'b1;
          stateNext = RETURN;
        end else if (waitExpired) begin
          dataLoad  = 1'b1;
          dataNext  = '0;
          stateNext = RETURN;
        end
      end
      RETURN:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      grant           <= '0;
      rrPtr           <= IdxW'(NUM_REQ - 1);
      oMemReadAddress <= '0;
      oReqReadData    <= '0;
    end else begin
      if (loadGrant) begin
        grant           <= nextGrant;
        oMemReadAddress <= pendAddr[nextGrant];
      end
      if (dataLoad) oReqReadData <= dataNext;
      if (state == RETURN) rrPtr <= grant;
    end
  end

  // A pulse arriving while its slot is being released starts a fresh request.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pending  <= '0;
      oOverrun <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pendAddr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (iReqReadReq[i] && (!pending[i] || clrVec[i])) begin
          pending[i]  <= 1'b1;
          pendAddr[i] <= iReqReadAddress[i*AW +: AW];
        end else if (clrVec[i]) begin
          pending[i] <= 1'b0;
        end
        if (iReqReadReq[i] && pending[i] && !clrVec[i]) oOverrun <= 1'b1;
      end
    end
  end

`ifdef LOADER_ARB_TIMEOUT_EN
  logic [15:0] waitCnt;
  logic        timeoutQ;

  assign waitExpired = (waitCnt == '0);
  assign oTimeout    = timeoutQ;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      if (state == ISSUE)
        waitCnt <= 16'(TIMEOUT_CYCLES - 1);
      else if (state == WAIT && waitCnt != '0)
        waitCnt <= waitCnt - 16'd1;
      if (state == WAIT && !iMemReadDataValid && waitExpired) timeoutQ <= 1'b1;
    end
  end
`else
  assign waitExpired = 1'b0;
  assign oTimeout    = 1'b0;
`endif

endmodule

// File: tb/tb_loader_read_arbiter.sv
// Directed self-checking bench for loader_read_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_loader_read_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            iClk = 1'b0;
  logic            iReset;
  logic [NR-1:0]   iReqReadReq;
  logic [NR*AW-1:0] iReqReadAddress;
  logic [DW-1:0]   oReqReadData;
  logic [NR-1:0]   oReqReadDataValid;
  logic [NR-1:0]   oReqBusy;
  logic            oMemReadReq;
  logic [AW-1:0]   oMemReadAddress;
  logic [DW-1:0]   iMemReadData;
  logic            iMemReadDataValid;
  logic            oOverrun;
  logic            oTimeout;

  int checks   = 0;
  int failures = 0;

  loader_read_arbiter #(
    .NUM_REQ(NR), .INTERFACE_WIDTH(DW), .INTERFACE_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iReqReadReq(iReqReadReq), .iReqReadAddress(iReqReadAddress),
    .oReqReadData(oReqReadData), .oReqReadDataValid(oReqReadDataValid),
    .oReqBusy(oReqBusy), .oMemReadReq(oMemReadReq), .oMemReadAddress(oMemReadAddress),
    .iMemReadData(iMemReadData), .iMemReadDataValid(iMemReadDataValid),
    .oOverrun(oOverrun), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset;
    iReset = 1'b1; iReqReadReq = '0; iReqReadAddress = '0;
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    tick; tick;
    iReset = 1'b0;
    checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b exp=0", oMemReadReq); end
    checks++; if (oMemReadAddress !== 32'h0) begin failures++; $display("FAIL reset_memaddr got=%h exp=0", oMemReadAddress); end
    checks++; if (oReqReadData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", oReqReadData); end
    checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", oReqReadDataValid); end
    checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", oReqBusy); end
    checks++; if (oOverrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", oOverrun); end
    checks++; if (oTimeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", oTimeout); end
  endtask

  task automatic test_single;
    iReqReadReq = 2'b01; iReqReadAddress = {32'h0, 32'h40};
    tick; // cycle 1
    iReqReadReq = '0;
    checks++; if (oReqBusy !== 2'b01) begin failures++; $display("FAIL single_busy got=%b exp=01", oReqBusy); end
    checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL single_memreq_c1 got=%b exp=0", oMemReadReq); end
    tick; // cycle 2
    checks++; if (oMemReadReq !== 1'b1) begin failures++; $display("FAIL single_memreq_c2 got=%b exp=1", oMemReadReq); end
    checks++; if (oMemReadAddress !== 32'h40) begin failures++; $display("FAIL single_addr got=%h exp=40", oMemReadAddress); end
    tick; // cycle 3
    checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL single_memreq_c3 got=%b exp=0", oMemReadReq); end
    checks++; if (oMemReadAddress !== 32'h40) begin failures++; $display("FAIL single_addr_hold got=%h exp=40", oMemReadAddress); end
    tick; tick; // cycle 5
    iMemReadDataValid = 1'b1; iMemReadData = 32'hDEADBEEF;
    checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL single_early_valid got=%b exp=00", oReqReadDataValid); end
    tick; // cycle 6
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    checks++; if (oReqReadDataValid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", oReqReadDataValid); end
    checks++; if (oReqReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", oReqReadData); end
    tick; // cycle 7
    checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL single_valid_end got=%b exp=00", oReqReadDataValid); end
    checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL single_busy_end got=%b exp=00", oReqBusy); end
    checks++; if (oReqReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data_hold got=%h exp=deadbeef", oReqReadData); end
  endtask

  task automatic test_stray;
    for (int c = 0; c < 3; c++) begin
      iMemReadDataValid = 1'b1; iMemReadData = 32'hCAFEF00D;
      tick;
      checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL stray_valid got=%b exp=00", oReqReadDataValid); end
      checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL stray_memreq got=%b exp=0", oMemReadReq); end
      checks++; if (oReqReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL stray_data got=%h exp=deadbeef", oReqReadData); end
      checks++; if (oMemReadAddress !== 32'h40) begin failures++; $display("FAIL stray_addr got=%h exp=40", oMemReadAddress); end
      checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL stray_busy got=%b exp=00", oReqBusy); end
    end
    iMemReadDataValid = 1'b0; iMemReadData = '0;
  endtask

  task automatic test_simultaneous;
    logic [NR-1:0] expStrobe, expBusy;
    for (int rep = 0; rep < 2; rep++) begin
      iReqReadReq = 2'b11; iReqReadAddress = {32'h20, 32'h10};
      for (int c = 1; c <= 9; c++) begin
        tick;
        iReqReadReq = '0;
        iMemReadDataValid = (c == 3 || c == 7);
        iMemReadData = (c == 3) ? 32'h1111_0010 : (c == 7) ? 32'h2222_0020 : 32'h0;
        checks++; if (oMemReadReq !== (c == 2 || c == 6)) begin failures++; $display("FAIL simul_memreq rep=%0d c=%0d got=%b", rep, c, oMemReadReq); end
        if (c == 2) begin checks++; if (oMemReadAddress !== 32'h10) begin failures++; $display("FAIL simul_addr0 rep=%0d got=%h exp=10", rep, oMemReadAddress); end end
        if (c == 6) begin checks++; if (oMemReadAddress !== 32'h20) begin failures++; $display("FAIL simul_addr1 rep=%0d got=%h exp=20", rep, oMemReadAddress); end end
        expStrobe = (c == 4) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
        expBusy   = (c <= 4) ? 2'b11 : (c <= 8) ? 2'b10 : 2'b00;
        checks++; if (oReqReadDataValid !== expStrobe) begin failures++; $display("FAIL simul_valid rep=%0d c=%0d got=%b exp=%b", rep, c, oReqReadDataValid, expStrobe); end
        checks++; if (oReqBusy !== expBusy) begin failures++; $display("FAIL simul_busy rep=%0d c=%0d got=%b exp=%b", rep, c, oReqBusy, expBusy); end
        if (c == 4) begin checks++; if (oReqReadData !== 32'h1111_0010) begin failures++; $display("FAIL simul_data0 got=%h exp=11110010", oReqReadData); end end
        if (c == 8) begin checks++; if (oReqReadData !== 32'h2222_0020) begin failures++; $display("FAIL simul_data1 got=%h exp=22220020", oReqReadData); end end
      end
    end
  endtask

  task automatic test_overrun;
    checks++; if (oOverrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", oOverrun); end
    iReqReadReq = 2'b10; iReqReadAddress = {32'h100, 32'h0};
    tick; // cycle 1
    iReqReadReq = 2'b10; iReqReadAddress = {32'h200, 32'h0};
    checks++; if (oReqBusy !== 2'b10) begin failures++; $display("FAIL overrun_busy got=%b exp=10", oReqBusy); end
    tick; // cycle 2
    iReqReadReq = '0;
    checks++; if (oOverrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", oOverrun); end
    checks++; if (oMemReadReq !== 1'b1) begin failures++; $display("FAIL overrun_memreq got=%b exp=1", oMemReadReq); end
    checks++; if (oMemReadAddress !== 32'h100) begin failures++; $display("FAIL overrun_addr got=%h exp=100", oMemReadAddress); end
    tick; // cycle 3
    iMemReadDataValid = 1'b1; iMemReadData = 32'h0BAD_0100;
    tick; // cycle 4
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    checks++; if (oReqReadDataValid !== 2'b10) begin failures++; $display("FAIL overrun_valid got=%b exp=10", oReqReadDataValid); end
    checks++; if (oReqReadData !== 32'h0BAD_0100) begin failures++; $display("FAIL overrun_data got=%h exp=0bad0100", oReqReadData); end
    for (int c = 5; c <= 8; c++) begin
      tick;
      checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL overrun_second_read c=%0d got=%b exp=0", c, oMemReadReq); end
      checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL overrun_busy_end c=%0d got=%b exp=00", c, oReqBusy); end
    end
    checks++; if (oOverrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", oOverrun); end
  endtask

  task automatic test_collision;
    iReqReadReq = 2'b01; iReqReadAddress = {32'h0, 32'h30};
    tick; iReqReadReq = '0;  // cycle 1
    tick;                    // cycle 2
    checks++; if (oMemReadAddress !== 32'h30) begin failures++; $display("FAIL coll_addr0 got=%h exp=30", oMemReadAddress); end
    tick;                    // cycle 3
    iMemReadDataValid = 1'b1; iMemReadData = 32'h3333_0030;
    tick;                    // cycle 4: RETURN with a new pulse
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    iReqReadReq = 2'b01; iReqReadAddress = {32'h0, 32'h80};
    checks++; if (oReqReadDataValid !== 2'b01) begin failures++; $display("FAIL coll_valid0 got=%b exp=01", oReqReadDataValid); end
    tick;                    // cycle 5
    iReqReadReq = '0;
    checks++; if (oReqBusy !== 2'b01) begin failures++; $display("FAIL coll_busy got=%b exp=01", oReqBusy); end
    tick;                    // cycle 6
    checks++; if (oMemReadReq !== 1'b1) begin failures++; $display("FAIL coll_memreq got=%b exp=1", oMemReadReq); end
    checks++; if (oMemReadAddress !== 32'h80) begin failures++; $display("FAIL coll_addr1 got=%h exp=80", oMemReadAddress); end
    tick;                    // cycle 7
    iMemReadDataValid = 1'b1; iMemReadData = 32'h8888_0080;
    tick;                    // cycle 8
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    checks++; if (oReqReadDataValid !== 2'b01) begin failures++; $display("FAIL coll_valid1 got=%b exp=01", oReqReadDataValid); end
    checks++; if (oReqReadData !== 32'h8888_0080) begin failures++; $display("FAIL coll_data got=%h exp=88880080", oReqReadData); end
    tick;                    // cycle 9
    checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL coll_busy_end got=%b exp=00", oReqBusy); end
    checks++; if (oOverrun !== 1'b0) begin failures++; $display("FAIL coll_overrun got=%b exp=0", oOverrun); end
  endtask

  task automatic test_timeout;
    logic [NR-1:0] expStrobe, expBusy;
    logic          expTo;
    iReqReadReq = 2'b01; iReqReadAddress = {32'h0, 32'h60};
    for (int c = 1; c <= 12; c++) begin
      tick;
      iReqReadReq = '0;
`ifdef LOADER_ARB_TIMEOUT_EN
      expStrobe = (c == 11) ? 2'b01 : 2'b00;
      expTo     = (c >= 11);
      expBusy   = (c <= 11) ? 2'b01 : 2'b00;
      if (c == 11) begin checks++; if (oReqReadData !== 32'h0) begin failures++; $display("FAIL timeout_data got=%h exp=0", oReqReadData); end end
`else
      expStrobe = 2'b00;
      expTo     = 1'b0;
      expBusy   = 2'b01;
`endif
      checks++; if (oMemReadReq !== (c == 2)) begin failures++; $display("FAIL timeout_memreq c=%0d got=%b", c, oMemReadReq); end
      checks++; if (oReqReadDataValid !== expStrobe) begin failures++; $display("FAIL timeout_valid c=%0d got=%b exp=%b", c, oReqReadDataValid, expStrobe); end
      checks++; if (oTimeout !== expTo) begin failures++; $display("FAIL timeout_flag c=%0d got=%b exp=%b", c, oTimeout, expTo); end
      checks++; if (oReqBusy !== expBusy) begin failures++; $display("FAIL timeout_busy c=%0d got=%b exp=%b", c, oReqBusy, expBusy); end
    end
`ifndef LOADER_ARB_TIMEOUT_EN
    iMemReadDataValid = 1'b1; iMemReadData = 32'h6666_0060;
    tick;
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    checks++; if (oReqReadDataValid !== 2'b01) begin failures++; $display("FAIL nowait_valid got=%b exp=01", oReqReadDataValid); end
    checks++; if (oReqReadData !== 32'h6666_0060) begin failures++; $display("FAIL nowait_data got=%h exp=66660060", oReqReadData); end
    tick;
    checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL nowait_busy got=%b exp=00", oReqBusy); end
`endif
  endtask

  task automatic test_reset_in_wait;
    iReqReadReq = 2'b01; iReqReadAddress = {32'h0, 32'h50};
    tick; iReqReadReq = '0;  // cycle 1
    tick;                    // cycle 2
    checks++; if (oMemReadReq !== 1'b1) begin failures++; $display("FAIL rstwait_memreq got=%b exp=1", oMemReadReq); end
    tick;                    // cycle 3: WAIT
    iReset = 1'b1;
    tick;                    // cycle 4
    iReset = 1'b0;
    iMemReadDataValid = 1'b1; iMemReadData = 32'h5555_0050;
    checks++; if (oReqBusy !== 2'b00) begin failures++; $display("FAIL rstwait_busy got=%b exp=00", oReqBusy); end
    checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL rstwait_valid got=%b exp=00", oReqReadDataValid); end
    checks++; if (oMemReadAddress !== 32'h0) begin failures++; $display("FAIL rstwait_addr got=%h exp=0", oMemReadAddress); end
    checks++; if (oTimeout !== 1'b0) begin failures++; $display("FAIL rstwait_timeout got=%b exp=0", oTimeout); end
    tick;                    // cycle 5
    iMemReadDataValid = 1'b0; iMemReadData = '0;
    checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL rstwait_late_valid got=%b exp=00", oReqReadDataValid); end
    checks++; if (oReqReadData !== 32'h0) begin failures++; $display("FAIL rstwait_data got=%h exp=0", oReqReadData); end
    for (int c = 6; c <= 9; c++) begin
      tick;
      checks++; if (oMemReadReq !== 1'b0) begin failures++; $display("FAIL rstwait_idle c=%0d got=%b exp=0", c, oMemReadReq); end
      checks++; if (oReqReadDataValid !== 2'b00) begin failures++; $display("FAIL rstwait_idle_valid c=%0d got=%b exp=00", c, oReqReadDataValid); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_stray;
    test_reset;
    test_simultaneous;
    test_overrun;
    test_reset;
    test_collision;
    test_timeout;
    test_reset_in_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
